// File: rtl/ofm_store_pkg.sv
// ofm_store_pkg: shared widths, OFM geometry defaults and store FSM states
package ofm_store_pkg;
  localparam int DATA_WIDTH = 25;
  localparam int ADDR_WIDTH = 10;
  localparam int OFM_C_DEF = 1;
  localparam int OFM_H_DEF = 10;
  localparam int OFM_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/ofm_fifo2w.sv
// ofm_fifo2w: 2-push/1-pop synchronous FIFO reporting free entries
module ofm_fifo2w #(
  parameter int width = 35,
  parameter int depth = 16,
  parameter int aw = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push0,
  input  logic [width-1:0] din0,
  input  logic             push1,
  input  logic [width-1:0] din1,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic [aw:0]      free
);
  logic [width-1:0] mem_q [depth];
  logic [aw-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [aw:0] cnt_q, cnt_d;
  logic do_pop;
  always_comb begin
    do_pop = pop & (cnt_q != '0);
    rd_d = clr ? '0 : rd_q + aw'(do_pop);
    wr_d = clr ? '0 : wr_q + aw'(push0) + aw'(push1);
    cnt_d = clr ? '0 : cnt_q + (aw+1)'(push0) + (aw+1)'(push1) - (aw+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_q] <= din0;
    if (push1) mem_q[wr_q + aw'(1)] <= din1;
  end
  assign empty = (cnt_q == '0);
  assign dout = empty ? '0 : mem_q[rd_q];
  assign free = (aw+1)'(depth) - cnt_q;
endmodule

// File: rtl/ofm_store.sv
// ofm_store: queues write-back results with linear OFM addresses and drains them to SRAM
module ofm_store
  import ofm_store_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int OFM_C = OFM_C_DEF,
  parameter int OFM_H = OFM_H_DEF,
  parameter int OFM_W = OFM_W_DEF,
  parameter int addr_width = ADDR_WIDTH,
  parameter int fifo_depth = 16,
  parameter int fifo_addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [data_width-1:0] out_port0,
  input  logic [data_width-1:0] out_port1,
  input  logic                  port0_valid,
  input  logic                  port1_valid,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [addr_width-1:0] wr_addr,
  output logic [data_width-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  state_t state_q, state_d;
  logic [15:0] ow_q, ow_d, oh_q, oh_d, oc_q, oc_d, ow_n, oh_n, oc_n;
  logic [addr_width-1:0] ptr_q, ptr_d;
  logic err_q, err_d;
  logic pair, clr, push0, push1, pop, fifo_empty, fifo_last;
  logic [fifo_addr_width:0] fifo_free;
  logic [addr_width+data_width-1:0] fifo_dout;
  ofm_fifo2w #(
    .width(addr_width + data_width),
    .depth(fifo_depth),
    .aw(fifo_addr_width)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .push0(push0),
    .din0({ptr_q, out_port0}),
    .push1(push1),
    .din1({ptr_q + addr_width'(OFM_W), out_port1}),
    .pop(pop),
    .dout(fifo_dout),
    .empty(fifo_empty),
    .free(fifo_free)
  );
  assign wr_en = !fifo_empty;
  assign {wr_addr, wr_data} = fifo_dout;
  assign pop = wr_en & wr_ready;
  assign fifo_last = (fifo_free == (fifo_addr_width+1)'(fifo_depth - 1));
  assign busy = (state_q == RUN) | (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    ow_d = ow_q;
    oh_d = oh_q;
    oc_d = oc_q;
    ptr_d = ptr_q;
    err_d = err_q;
    clr = 1'b0;
    push0 = 1'b0;
    push1 = 1'b0;
    pair = port0_valid & port1_valid;
    ow_n = ow_q + 16'd1;
    oh_n = oh_q;
    oc_n = oc_q;
    if (start) begin
      if (state_q == IDLE) begin
        clr = 1'b1;
        ow_d = '0;
        oh_d = '0;
        oc_d = '0;
        ptr_d = '0;
        err_d = 1'b0;
        state_d = RUN;
      end else err_d = 1'b1;
    end
    if (port1_valid & !port0_valid) err_d = 1'b1;
    if ((state_q != RUN) & (port0_valid | port1_valid)) err_d = 1'b1;
    if ((state_q == RUN) & port0_valid) begin
      if (fifo_free >= (pair ? (fifo_addr_width+1)'(2) : (fifo_addr_width+1)'(1))) begin
        push0 = 1'b1;
        push1 = port1_valid;
        ptr_d = ptr_q + addr_width'(1);
        if (ow_n == 16'(OFM_W)) begin
          ow_n = '0;
          oh_n = oh_q + (pair ? 16'd2 : 16'd1);
          ptr_d = pair ? ptr_d + addr_width'(OFM_W) : ptr_d;
        end
        if (oh_n >= 16'(OFM_H)) begin
          oh_n = '0;
          oc_n = oc_q + 16'd1;
        end
        ow_d = ow_n;
        oh_d = oh_n;
        oc_d = oc_n;
        state_d = (oc_n == 16'(OFM_C)) ? DRAIN : RUN;
      end else err_d = 1'b1;
    end
    if ((state_q == DRAIN) & (fifo_empty | (fifo_last & pop))) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ow_q <= '0;
      oh_q <= '0;
      oc_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ow_q <= ow_d;
      oh_q <= oh_d;
      oc_q <= oc_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ofm_store.sv
// tb_ofm_store: directed self-checking bench for ofm_store
module tb_ofm_store;
  logic clk = 1'b0;
  logic rst_n, start, p0v, p1v, wr_ready, wr_en, busy, done, err;
  logic [24:0] d0, d1, wr_data;
  logic [9:0] wr_addr;
  int pass_cnt = 0, total_cnt = 0;
  int wcnt = 0, done_cnt = 0, cyc = 0, hs_cyc = 0, done_cyc = 0;
  int log_a [1024];
  int log_d [1024];
  int base, dbase;
  ofm_store dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .out_port0(d0), .out_port1(d1),
    .port0_valid(p0v), .port1_valid(p1v),
    .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (wr_en && wr_ready && wcnt < 1024) begin
      log_a[wcnt] = int'(wr_addr);
      log_d[wcnt] = int'(wr_data);
      wcnt++;
      hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic beat(input logic v0, input logic v1, input int x, input int y);
    p0v = v0;
    p1v = v1;
    d0 = 25'(x);
    d1 = 25'(y);
    @(posedge clk);
    #1;
    p0v = 1'b0;
    p1v = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic pair_rows(input int from, input bit gap);
    for (int oh = from; oh < 10; oh += 2)
      for (int ow = 0; ow < 8; ow++) begin
        beat(1'b1, 1'b1, oh * 8 + ow, (oh + 1) * 8 + ow);
        if (gap) idle(1);
      end
  endtask
  task automatic wait_done(input string tag, input int d);
    int n;
    n = 0;
    while (done_cnt == d && n < 400) begin
      idle(1);
      n++;
    end
    chk({tag, " done_seen"}, 64'(done_cnt > d), 64'd1);
  endtask
  task automatic check_map(input string tag, input int b);
    int bad;
    bit seen [80];
    bad = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    chk({tag, " write_count"}, 64'(wcnt - b), 64'd80);
    for (int i = b; i < wcnt; i++) begin
      if (log_a[i] < 0 || log_a[i] >= 80 || log_d[i] != log_a[i]) bad++;
      else begin
        if (seen[log_a[i]]) bad++;
        seen[log_a[i]] = 1'b1;
      end
    end
    chk({tag, " bad_entries"}, 64'(bad), 64'd0);
  endtask
  task automatic check_burst16(input string tag, input int b);
    int bad;
    bad = 0;
    chk({tag, " write_count"}, 64'(wcnt - b), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (log_a[b + i] != ((i % 2) ? 8 + i / 2 : i / 2) || log_d[b + i] != log_a[b + i]) bad++;
    end
    chk({tag, " order"}, 64'(bad), 64'd0);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    p0v = 1'b0;
    p1v = 1'b0;
    d0 = '0;
    d1 = '0;
    wr_ready = 1'b1;
    idle(3);
    chk("rst wr_en", 64'(wr_en), 64'd0);
    chk("rst wr_addr", 64'(wr_addr), 64'd0);
    chk("rst wr_data", 64'(wr_data), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    rst_n = 1'b1;
    idle(1);
    base = wcnt;
    dbase = done_cnt;
    do_start();
    chk("pair busy", 64'(busy), 64'd1);
    pair_rows(0, 1'b1);
    wait_done("pair", dbase);
    chk("pair done_latency", 64'(done_cyc - hs_cyc), 64'd1);
    check_map("pair", base);
    idle(3);
    chk("pair done_once", 64'(done_cnt - dbase), 64'd1);
    chk("pair err", 64'(err), 64'd0);
    chk("pair busy_end", 64'(busy), 64'd0);
    base = wcnt;
    dbase = done_cnt;
    do_start();
    for (int a = 0; a < 80; a++) beat(1'b1, 1'b0, a, 0);
    wait_done("single", dbase);
    chk("single done_latency", 64'(done_cyc - hs_cyc), 64'd1);
    check_map("single", base);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 80; i++) if (log_a[base + i] != i) bad++;
      chk("single order", 64'(bad), 64'd0);
    end
    chk("single err", 64'(err), 64'd0);
    base = wcnt;
    dbase = done_cnt;
    wr_ready = 1'b0;
    do_start();
    for (int ow = 0; ow < 8; ow++) beat(1'b1, 1'b1, ow, 8 + ow);
    idle(11);
    chk("bp wr_en", 64'(wr_en), 64'd1);
    chk("bp wr_addr_hold", 64'(wr_addr), 64'd0);
    chk("bp no_write", 64'(wcnt - base), 64'd0);
    chk("bp err", 64'(err), 64'd0);
    wr_ready = 1'b1;
    idle(18);
    check_burst16("bp", base);
    pair_rows(2, 1'b1);
    wait_done("bp", dbase);
    check_map("bp", base);
    chk("bp err_end", 64'(err), 64'd0);
    base = wcnt;
    dbase = done_cnt;
    wr_ready = 1'b0;
    do_start();
    for (int ow = 0; ow < 8; ow++) beat(1'b1, 1'b1, ow, 8 + ow);
    chk("ovf err_before", 64'(err), 64'd0);
    beat(1'b1, 1'b1, 16, 24);
    chk("ovf err", 64'(err), 64'd1);
    idle(3);
    chk("ovf no_write", 64'(wcnt - base), 64'd0);
    wr_ready = 1'b1;
    idle(18);
    check_burst16("ovf", base);
    pair_rows(2, 1'b1);
    wait_done("ovf", dbase);
    check_map("ovf", base);
    chk("ovf err_sticky", 64'(err), 64'd1);
    do_start();
    chk("start clears err", 64'(err), 64'd0);
    base = wcnt;
    beat(1'b0, 1'b1, 5, 5);
    chk("lone1 err", 64'(err), 64'd1);
    idle(3);
    chk("lone1 no_write", 64'(wcnt - base), 64'd0);
    chk("lone1 busy", 64'(busy), 64'd1);
    wr_ready = 1'b0;
    for (int ow = 0; ow < 3; ow++) beat(1'b1, 1'b1, ow, 8 + ow);
    chk("pre_rst wr_en", 64'(wr_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst wr_addr", 64'(wr_addr), 64'd0);
    chk("mid_rst wr_data", 64'(wr_data), 64'd0);
    chk("mid_rst busy", 64'(busy), 64'd0);
    chk("mid_rst err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    idle(5);
    chk("post_rst no_write", 64'(wcnt - base), 64'd0);
    chk("post_rst wr_en", 64'(wr_en), 64'd0);
    base = wcnt;
    dbase = done_cnt;
    do_start();
    pair_rows(0, 1'b1);
    wait_done("after_rst", dbase);
    check_map("after_rst", base);
    chk("after_rst err", 64'(err), 64'd0);
    idle(2);
    base = wcnt;
    beat(1'b1, 1'b0, 3, 0);
    chk("idle_beat err", 64'(err), 64'd1);
    idle(3);
    chk("idle_beat no_write", 64'(wcnt - base), 64'd0);
    chk("idle_beat busy", 64'(busy), 64'd0);
    do_start();
    chk("idle_beat start_clears", 64'(err), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ofm_store.md
# ofm_store

Output-feature-map store stage that sits directly downstream of the write-back controller. It accepts the controller's two output ports (`port0` holds row h, `port1` holds row h+1, same column) and generates linear OFM addresses in channel/row/column order. Each result is queued, with its address, in a small 2-in/1-out FIFO. Results are drained through a single valid/ready write port into OFM SRAM, and a one-cycle done pulse marks the completion of the full map.

## Interface
Parameters:
- `data_width`, 25, result width, matching the partial-sum buffer width
- `OFM_C`, 1, output channels
- `OFM_H`, 10, output rows
- `OFM_W`, 8, output columns
- `addr_width`, 10, SRAM address width; must satisfy 2^addr_width ≥ OFM_C·OFM_H·OFM_W
- `fifo_depth`, 16, FIFO entries, power of two, ≥ 2
- `fifo_addr_width`, 4, log2(fifo_depth)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; clears counters and begins a map
- `out_port0`  in  data_width  result for row oh, column ow
- `out_port1`  in  data_width  result for row oh+1, column ow
- `port0_valid`  in  1  out_port0 valid this cycle
- `port1_valid`  in  1  out_port1 valid this cycle; legal only with port0_valid
- `wr_en`  out  1  SRAM write request (valid)
- `wr_ready`  in  1  SRAM accepts the write this cycle
- `wr_addr`  out  addr_width  linear address oc·H·W + oh·W + ow
- `wr_data`  out  data_width  result
- `busy`  out  1  a map is in progress (RUN or DRAIN)
- `done`  out  1  one-cycle pulse when the map is complete
- `err`  out  1  sticky protocol or overflow error, cleared by start or reset

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: accepts beats. Moves to DRAIN in the cycle the final coordinate is accepted.
  - DRAIN: waits for the FIFO to empty and the last handshake to complete, then moves to DONE.
  - DONE: 1 cycle, `done`=1, then IDLE.
- `start` in IDLE clears ow, oh, oc, ptr, `err` and the FIFO, then enters RUN. `start` in any other state is ignored and sets `err`.
- Pair beat (port0_valid & port1_valid) in RUN:
  - Push {ptr, port0}, then {ptr+OFM_W, port1}.
  - ow++, ptr++.
  - At ow==OFM_W: ow=0, oh+=2, ptr+=OFM_W (skips the row already written by port1).
- Single beat (port0_valid only): push {ptr, port0}; ow++, ptr++; at ow==OFM_W: ow=0, oh+=1.
- oh==OFM_H → oh=0, oc++. oc==OFM_C ends RUN.
- Beat stepping is decided per beat. Mixing pair and single beats within one row pair is a producer error; it is not detected.
- port1_valid without port0_valid: nothing is pushed, counters hold, `err`=1.
- Valid beats in IDLE, DRAIN or DONE are ignored, and `err`=1.
- Overflow (a pair with free<2, or a single with free<1): the whole beat is dropped, counters hold, `err`=1. A beat is never partially pushed.
- Arithmetic:
  - ptr is unsigned addr_width and wraps modulo 2^addr_width; the parameter rule prevents wrap in legal use.
  - Data passes through unmodified, with no sign handling.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0; state IDLE; FIFO empty.
- Latency: an entry pushed at edge N can drive `wr_en` from cycle N+1.
- Handshake: once `wr_en`=1, `wr_addr`/`wr_data` hold stable until `wr_en & wr_ready`; a transfer occurs on that edge.
- Throughput: back-to-back writes at 1 per cycle while `wr_ready`=1.
- FIFO ordering: port0 entry before port1 entry.
- Simultaneous push and pop: free count is evaluated before the pop, so a pop does not create room for a push in the same cycle.
- `done` asserts the cycle after the final handshake edge. `busy` drops in the same cycle `done` rises.
- Reset asserted mid-map: all state clears immediately and any pending write is lost.

## Structure
- Shared package holds the data and address widths and the OFM_C/H/W defaults, shared with the write-back controller and the partial-sum buffer.
- One sub-module, `ofm_fifo2w`: a 2-push/1-pop synchronous FIFO with entries of {addr, data}, a free count, push0/push1 enables, and a pop.

## Test plan
- 1×10×8 map, 40 pair beats of value (oh·8+ow), `wr_ready`=1 → 80 writes, addr 0..79, mem[a]==a, `done` once, `err`=0.
- Same map as 80 single beats → identical memory and the same address order.
- `wr_ready`=0 for 20 cycles during 8 pair beats → FIFO reaches 16, no loss, 16 writes in order once ready returns.
- `wr_ready`=0 with 9 pair beats → `err`=1 and the 9th pair is absent; the rest are correct.
- port1_valid alone, and a beat in IDLE → no write, `err`=1; a following `start` clears `err`.
- `rst_n` pulsed low mid-map with the FIFO non-empty → outputs at reset values at once, no further `wr_en`; a new `start` completes a full map correctly.
